ws_strip_router: RTL and testbench
==================================

WS_STRIP_ROUTER -- requirements
Module: ws_strip_router

Interface
REQ-001 SHALL have parameter N_CH, default 4, number of LED strip channels (legal 1..16).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 100000, maximum idle cycles allowed between bytes inside a frame.
REQ-003 SHALL have parameter SYNC_BYTE, default 8'hA5, frame start marker.
REQ-004 SHALL have parameter BCAST_CH, default 8'hFF, channel value meaning "all channels".
REQ-005 SHALL have port i_clk  input  1  sole clock; all logic rising-edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port i_rx_valid  input  1  one-cycle strobe from UART receiver; byte present.
REQ-008 SHALL have port i_rx_data  input  8  received byte, sampled only when i_rx_valid=1.
REQ-009 SHALL have port o_rgb  output  N_CH*24  colour registers; channel k at [24k+23:24k], fields {G[23:16],R[15:8],B[7:0]} matching the strip serializer inputs.
REQ-010 SHALL have port o_upd  output  N_CH  one-cycle per-channel update strobe.
REQ-011 SHALL have port o_busy  output  1  high while a frame is in progress (state not IDLE).
REQ-012 SHALL have port o_err  output  1  one-cycle pulse on frame rejection.
REQ-013 SHALL have port o_err_code  output  2  cause of last rejection: 0 none, 1 checksum, 2 bad channel, 3 timeout; held until next SYNC_BYTE accepted.

Function
REQ-014 Frame SHALL be 6 bytes: SYNC, CH, G, R, B, CHK, with CHK = CH ^ G ^ R ^ B.
REQ-015 FSM states SHALL be IDLE, S_CH, S_G, S_R, S_B, S_CHK; each valid byte advances one state; IDLE->S_CH only on byte == SYNC_BYTE.
REQ-016 Non-SYNC bytes in IDLE SHALL be ignored silently (no o_err).
REQ-017 On CHK byte: if checksum matches and CH < N_CH, channel CH register SHALL load {G,R,B} and o_upd[CH] SHALL pulse; both visible the cycle after the CHK strobe.
REQ-018 CH == BCAST_CH with good checksum SHALL load all N_CH registers and pulse all o_upd bits in the same cycle.
REQ-019 Checksum mismatch SHALL discard the frame, pulse o_err, set o_err_code=1; checksum takes priority over bad channel.
REQ-020 Good checksum with CH >= N_CH and CH != BCAST_CH SHALL discard, pulse o_err, set o_err_code=2.
REQ-021 After the CHK byte the FSM SHALL return to IDLE regardless of outcome.
REQ-022 Timeout counter SHALL clear on every valid byte and count while not IDLE; reaching TIMEOUT_CYC SHALL return FSM to IDLE, pulse o_err, set o_err_code=3, discard partial frame.
REQ-023 A valid byte in the same cycle the counter reaches TIMEOUT_CYC SHALL be accepted; timeout not raised.
REQ-024 SYNC_BYTE received mid-frame SHALL be treated as data, not resync.
REQ-025 Unaddressed channel registers SHALL hold value; o_upd SHALL be 0 except on commit cycles.
REQ-026 o_err_code SHALL clear to 0 on the cycle after a SYNC_BYTE is accepted in IDLE.

Reset
REQ-027 rst SHALL asynchronously force: FSM IDLE, all o_rgb 0, o_upd 0, o_busy 0, o_err 0, o_err_code 0, timeout counter 0, byte holding registers 0.
REQ-028 Reset mid-frame SHALL discard the partial frame with no o_upd or o_err pulse.

Structure
REQ-029 Shared package SHALL hold the FSM state encoding, error code constants (ERR_NONE/CHK/CH/TMO), default SYNC_BYTE and BCAST_CH.
REQ-030 Timeout counter SHALL be the single sub-module ws_byte_timer (params TIMEOUT_CYC; ports clear, enable, expired); counter width $clog2(TIMEOUT_CYC+1).
REQ-031 Channel index decode SHALL be generated over N_CH; no fixed-4 hardcoding.

Verification
REQ-032 N_CH=4: bytes A5,02,10,20,30,02 -> next cycle o_rgb[71:48]=0x102030, o_upd=4'b0100, others unchanged, o_err=0.
REQ-033 Bytes A5,FF,01,02,03,FF -> all four channels =0x010203, o_upd=4'b1111.
REQ-034 Bytes A5,01,10,20,30,00 -> no register change, o_err pulse, o_err_code=1; then A5,05,00,00,00,05 -> o_err pulse, o_err_code=2.
REQ-035 TIMEOUT_CYC=50: A5,01,10 then 50 idle cycles -> FSM IDLE, o_err pulse, o_err_code=3, o_busy 0; a byte arriving on cycle 50 instead -> frame continues.
REQ-036 Assert rst after A5,03,AA -> all outputs 0 immediately; subsequent full frame for channel 3 commits normally.

Source files
------------

// File: rtl/ws_strip_router_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ws_strip_router_pkg
// Description : Shared frame-parser state encoding, error codes and defaults.
// Revision    : 1.0 - initial release
// ============================================================================
package ws_strip_router_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    S_CH  = 3'd1,
    S_G   = 3'd2,
    S_R   = 3'd3,
    S_B   = 3'd4,
    S_CHK = 3'd5
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_CHK  = 2'd1;
  localparam logic [1:0] ERR_CH   = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
  localparam logic [7:0] DEF_BCAST_CH  = 8'hFF;

endpackage
`default_nettype wire

// File: rtl/ws_byte_timer.sv
`default_nettype none
// ============================================================================
// Module      : ws_byte_timer
// Description : Inter-byte idle counter; flags the TIMEOUT_CYC-th idle cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ws_byte_timer #(
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic i_clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clear || !enable) begin
      r_cnt <= '0;
    end else if (r_cnt != CNT_W'(TIMEOUT_CYC)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // r_cnt holds idle cycles already elapsed, so this cycle is the
  // TIMEOUT_CYC-th one; a byte arriving now (clear) still wins.
  assign expired = enable && !clear && (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule
`default_nettype wire

// File: rtl/ws_strip_router.sv
`default_nettype none
// ============================================================================
// Module      : ws_strip_router
// Description : UART frame parser routing {G,R,B} colours to LED strip channels.
// Revision    : 1.0 - initial release
// ============================================================================
module ws_strip_router
  import ws_strip_router_pkg::*;
#(
  parameter int         N_CH        = 4,
  parameter int         TIMEOUT_CYC = 100000,
  parameter logic [7:0] SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter logic [7:0] BCAST_CH    = DEF_BCAST_CH
) (
  input  logic                 i_clk,
  input  logic                 rst,
  input  logic                 i_rx_valid,
  input  logic [7:0]           i_rx_data,
  output logic [N_CH*24-1:0]   o_rgb,
  output logic [N_CH-1:0]      o_upd,
  output logic                 o_busy,
  output logic                 o_err,
  output logic [1:0]           o_err_code
);

  state_t              r_state;
  logic [7:0]          r_ch;
  logic [7:0]          r_g;
  logic [7:0]          r_r;
  logic [7:0]          r_b;
  logic [N_CH*24-1:0]  r_rgb;
  logic [N_CH-1:0]     r_upd;
  logic                r_err;
  logic [1:0]          r_err_code;

  logic [N_CH-1:0]     w_sel;
  logic                w_busy;
  logic                w_expired;
  logic                w_chk_ok;
  logic                w_ch_ok;

  assign w_busy = (r_state != IDLE);

  ws_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .i_clk   (i_clk),
    .rst     (rst),
    .clear   (i_rx_valid),
    .enable  (w_busy),
    .expired (w_expired)
  );

  // One select bit per channel; broadcast selects every channel.
  generate
    for (genvar k = 0; k < N_CH; k++) begin : g_ch_dec
      assign w_sel[k] = (r_ch == 8'(k)) || (r_ch == BCAST_CH);
    end
  endgenerate

  assign w_chk_ok = ((r_ch ^ r_g ^ r_r ^ r_b) == i_rx_data);
  assign w_ch_ok  = |w_sel;

  always_ff @(posedge i_clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_ch       <= '0;
      r_g        <= '0;
      r_r        <= '0;
      r_b        <= '0;
      r_rgb      <= '0;
      r_upd      <= '0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
    end else begin
      r_upd <= '0;
      r_err <= 1'b0;
      if (i_rx_valid) begin
        unique case (r_state)
          IDLE: begin
            if (i_rx_data == SYNC_BYTE) begin
              r_state    <= S_CH;
              r_err_code <= ERR_NONE;
            end
          end
          S_CH: begin
            r_ch    <= i_rx_data;
            r_state <= S_G;
          end
          S_G: begin
            r_g     <= i_rx_data;
            r_state <= S_R;
          end
          S_R: begin
            r_r     <= i_rx_data;
            r_state <= S_B;
          end
          S_B: begin
            r_b     <= i_rx_data;
            r_state <= S_CHK;
          end
          S_CHK: begin
            r_state <= IDLE;
            // Checksum failure is reported ahead of a bad channel.
            if (!w_chk_ok) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CHK;
            end else if (!w_ch_ok) begin
              r_err      <= 1'b1;
              r_err_code <= ERR_CH;
            end else begin
              for (int k = 0; k < N_CH; k++) begin
                if (w_sel[k]) r_rgb[k*24 +: 24] <= {r_g, r_r, r_b};
              end
              r_upd <= w_sel;
            end
          end
          default: r_state <= IDLE;
        endcase
      end else if (w_expired) begin
        r_state    <= IDLE;
        r_err      <= 1'b1;
        r_err_code <= ERR_TMO;
      end
    end
  end

  assign o_rgb      = r_rgb;
  assign o_upd      = r_upd;
  assign o_busy     = w_busy;
  assign o_err      = r_err;
  assign o_err_code = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_ws_strip_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_ws_strip_router
// Description : Randomized scoreboard bench for ws_strip_router.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ws_strip_router;

  localparam int N_CH = 4;
  localparam int TMO  = 50;

  typedef struct packed {
    logic [N_CH-1:0]    upd;
    logic               err;
    logic [1:0]         code;
    logic [N_CH*24-1:0] rgb;
  } ev_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                rx_valid = 1'b0;
  logic [7:0]          rx_data = 8'h00;
  logic [N_CH*24-1:0]  rgb;
  logic [N_CH-1:0]     upd;
  logic                busy;
  logic                err;
  logic [1:0]          err_code;

  int n_checks = 0;
  int n_pass   = 0;

  ev_t        exp_q[$];
  ev_t        mon_e;
  logic [7:0] frame[$];
  logic [23:0] m_rgb[N_CH];
  logic [1:0] m_code;

  ws_strip_router #(
    .N_CH        (N_CH),
    .TIMEOUT_CYC (TMO),
    .SYNC_BYTE   (8'hA5),
    .BCAST_CH    (8'hFF)
  ) dut (
    .i_clk      (clk),
    .rst        (rst),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_rgb      (rgb),
    .o_upd      (upd),
    .o_busy     (busy),
    .o_err      (err),
    .o_err_code (err_code)
  );

  always #5 clk = ~clk;

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [N_CH*24-1:0] packed_rgb();
    logic [N_CH*24-1:0] v;
    for (int k = 0; k < N_CH; k++) v[k*24 +: 24] = m_rgb[k];
    return v;
  endfunction

  task automatic push_ev(input logic [N_CH-1:0] u, input logic e);
    ev_t ev;
    ev.upd  = u;
    ev.err  = e;
    ev.code = m_code;
    ev.rgb  = packed_rgb();
    exp_q.push_back(ev);
  endtask

  // A gap of TMO or more idle cycles inside a frame aborts it.
  task automatic model_gap(input int gap);
    if (frame.size() != 0 && gap >= TMO) begin
      m_code = 2'd3;
      push_ev('0, 1'b1);
      frame.delete();
    end
  endtask

  task automatic model_byte(input logic [7:0] b, output bit started);
    logic [7:0] ch, g, r, bl, chk;
    started = 1'b0;
    if (frame.size() == 0) begin
      if (b == 8'hA5) begin
        frame.push_back(b);
        m_code  = 2'd0;
        started = 1'b1;
      end
    end else begin
      frame.push_back(b);
      if (frame.size() == 6) begin
        ch = frame[1]; g = frame[2]; r = frame[3]; bl = frame[4]; chk = frame[5];
        if ((ch ^ g ^ r ^ bl) != chk) begin
          m_code = 2'd1;
          push_ev('0, 1'b1);
        end else if (ch == 8'hFF) begin
          for (int k = 0; k < N_CH; k++) m_rgb[k] = {g, r, bl};
          push_ev('1, 1'b0);
        end else if (int'(ch) < N_CH) begin
          m_rgb[ch] = {g, r, bl};
          push_ev(N_CH'(1) << ch, 1'b0);
        end else begin
          m_code = 2'd2;
          push_ev('0, 1'b1);
        end
        frame.delete();
      end
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    bit started;
    model_gap(gap);
    repeat (gap) begin @(posedge clk); #1; end
    model_byte(b, started);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'($urandom);
    if (started) begin
      check("busy_after_sync", busy, 1'b1);
      check("code_clear_after_sync", err_code, 2'd0);
    end
  endtask

  task automatic idle(input int n);
    model_gap(n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send6(input logic [47:0] f);
    for (int i = 5; i >= 0; i--) send(f[i*8 +: 8], 0);
  endtask

  function automatic int pick_gap();
    int r;
    r = int'($urandom_range(0, 19));
    if (r < 14) return 0;
    if (r < 17) return int'($urandom_range(1, 5));
    if (r == 17) return TMO - 1;
    if (r == 18) return TMO;
    return int'($urandom_range(TMO + 1, TMO + 10));
  endfunction

  always @(negedge clk) begin
    if (!rst && (upd != '0 || err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {upd, err}, '0);
      end else begin
        mon_e = exp_q.pop_front();
        check("upd", upd, mon_e.upd);
        check("err", err, mon_e.err);
        check("err_code", err_code, mon_e.code);
        check("rgb", rgb, mon_e.rgb);
      end
    end
  end

  initial begin
    logic [7:0] ch, g, r, b, chk, gb;
    int sel;
    for (int k = 0; k < N_CH; k++) m_rgb[k] = '0;
    m_code = 2'd0;

    #22;
    check("reset_rgb", rgb, '0);
    check("reset_upd", upd, '0);
    check("reset_busy", busy, 1'b0);
    check("reset_err", err, 1'b0);
    check("reset_code", err_code, 2'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send6(48'hA5_02_10_20_30_02);
    send6(48'hA5_FF_01_02_03_FF);
    send6(48'hA5_01_10_20_30_00);
    send6(48'hA5_05_00_00_00_05);
    idle(3);

    // Timeout after 50 idle cycles, then a byte on the last allowed cycle.
    send(8'hA5, 0); send(8'h01, 0); send(8'h10, 0);
    idle(TMO);
    check("busy_after_timeout", busy, 1'b0);
    check("code_after_timeout", err_code, 2'd3);
    send(8'hA5, 0); send(8'h01, 0); send(8'h10, 0);
    send(8'h20, TMO - 1);
    check("busy_late_byte", busy, 1'b1);
    send(8'h30, 0); send(8'h01, 0);

    // Reset in the middle of a frame.
    send(8'hA5, 0); send(8'h03, 0); send(8'hAA, 0);
    rst = 1'b1;
    frame.delete();
    for (int k = 0; k < N_CH; k++) m_rgb[k] = '0;
    m_code = 2'd0;
    #1;
    check("midreset_rgb", rgb, '0);
    check("midreset_busy", busy, 1'b0);
    check("midreset_code", err_code, 2'd0);
    check("midreset_upd_err", {upd, err}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    send6(48'hA5_03_11_22_33_03);
    idle(2);

    for (int it = 0; it < 150; it++) begin
      if ($urandom_range(0, 5) == 0) begin
        gb = 8'($urandom);
        if (gb == 8'hA5) gb = 8'h5A;
        send(gb, pick_gap());
      end
      sel = int'($urandom_range(0, 9));
      if (sel < 4) ch = 8'(sel);
      else if (sel < 6) ch = 8'hFF;
      else ch = 8'($urandom_range(4, 254));
      g = 8'($urandom); r = 8'($urandom); b = 8'($urandom);
      if ($urandom_range(0, 7) == 0) g = 8'hA5;
      chk = ch ^ g ^ r ^ b;
      if ($urandom_range(0, 4) == 0) chk = chk ^ 8'(($urandom_range(1, 255)));
      send(8'hA5, pick_gap());
      send(ch, pick_gap());
      send(g, pick_gap());
      send(r, pick_gap());
      send(b, pick_gap());
      send(chk, pick_gap());
    end

    idle(TMO + 10);
    check("queue_drained", 128'(exp_q.size()), 128'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
